// File: rtl/fwft_fifo_ctl.sv
// fwft_fifo_ctl: synchronous first-word-fall-through FIFO for any DEPTH >= 2,
// including non-power-of-two depths. Provides an occupancy count,
// almost-full/almost-empty thresholds and optional sticky error flags.
// Optional feature macro: FWFT_FIFO_ERR_EN (sticky overflow/underflow with err_clr).
// The head word lives in an output register; memory holds entries 2..count.
module fwft_fifo_ctl #(
   parameter int unsigned DWIDTH    = 32,
   parameter int unsigned DEPTH     = 6,
   parameter int unsigned AFULL_TH  = DEPTH - 1,
   parameter int unsigned AEMPTY_TH = 1,
   localparam int unsigned CWIDTH   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [DWIDTH-1:0] din,
   input  logic              read,
   output logic [DWIDTH-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CWIDTH-1:0] count,
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned IWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CWIDTH-1:0] count_q, count_d;
   logic [IWIDTH-1:0] wr_idx_q, wr_idx_d;
   logic [IWIDTH-1:0] rd_idx_q, rd_idx_d;
   logic [DWIDTH-1:0] head_q, head_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic wen, ren;
   logic load_din, load_mem, mem_we;

   // Indices wrap by explicit compare so non-power-of-two depths work.
   function automatic logic [IWIDTH-1:0] idx_next(input logic [IWIDTH-1:0] idx);
      return (idx == IWIDTH'(DEPTH - 1)) ? '0 : idx + IWIDTH'(1);
   endfunction

   // Status flags are decoded purely from the registered count.
   assign full         = (count_q == CWIDTH'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CWIDTH'(AFULL_TH));
   assign almost_empty = (count_q <= CWIDTH'(AEMPTY_TH));
   assign count        = count_q;
   assign dout         = head_q;

   // Accept decisions, head-register load selection and next-state values.
   always_comb begin
      wen      = write & ~full;
      ren      = read & ~empty;
      // Head takes din when it is empty, or is being popped with nothing behind it.
      load_din = wen && ((count_q == '0) || (ren && (count_q == CWIDTH'(1))));
      load_mem = !load_din && ren && (count_q >= CWIDTH'(2));
      mem_we   = wen && !load_din;

      head_d   = head_q;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      count_d  = count_q;

      if (load_din) begin
         head_d = din;
      end else if (load_mem) begin
         head_d   = mem_q[rd_idx_q];
         rd_idx_d = idx_next(rd_idx_q);
      end

      if (mem_we) begin
         wr_idx_d = idx_next(wr_idx_q);
      end

      unique case ({wen, ren})
         2'b10:   count_d = count_q + CWIDTH'(1);
         2'b01:   count_d = count_q - CWIDTH'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state and head register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         head_q   <= '0;
      end else begin
         count_q  <= count_d;
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         head_q   <= head_d;
      end
   end

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_idx_q] <= din;
      end
   end

`ifdef FWFT_FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   // Sticky error flags; a new error wins over a coincident clear.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (write && full) begin
         ovf_d = 1'b1;
      end
      if (read && empty) begin
         unf_d = 1'b1;
      end
   end

   // Error flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fwft_fifo_ctl.sv
// Self-checking bench for fwft_fifo_ctl (DEPTH=6, DWIDTH=8, AFULL_TH=5, AEMPTY_TH=1).
// Reference model is a plain queue of words plus a held head value.
module tb_fwft_fifo_ctl;

   localparam int DW = 8;
   localparam int DP = 6;
   localparam int AF = 5;
   localparam int AE = 1;

   logic          clk;
   logic          rst_n;
   logic          write;
   logic          read;
   logic          err_clr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [2:0]    count;
   logic          overflow;
   logic          underflow;

   int n_cmp = 0;
   int n_mis = 0;

   bit [DW-1:0] q[$];
   bit [DW-1:0] m_dout;
   bit          m_ovf;
   bit          m_unf;

   fwft_fifo_ctl #(
      .DWIDTH   (DW),
      .DEPTH    (DP),
      .AFULL_TH (AF),
      .AEMPTY_TH(AE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .write       (write),
      .din         (din),
      .read        (read),
      .dout        (dout),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count),
      .err_clr     (err_clr),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, required finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      int n;
      n = q.size();
      chk({ph, ".count"}, 32'(count), 32'(n));
      chk({ph, ".empty"}, 32'(empty), 32'(n == 0));
      chk({ph, ".full"}, 32'(full), 32'(n == DP));
      chk({ph, ".afull"}, 32'(almost_full), 32'(n >= AF));
      chk({ph, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
      chk({ph, ".dout"}, 32'(dout), 32'(m_dout));
      chk({ph, ".ovf"}, 32'(overflow), 32'(m_ovf));
      chk({ph, ".unf"}, 32'(underflow), 32'(m_unf));
   endtask

   // One clock of stimulus; model applies the rules using pre-edge occupancy.
   task automatic step(input string ph, input bit w, input bit [DW-1:0] d, input bit r,
                       input bit c);
      bit was_full, was_empty;
      write   = w;
      din     = d;
      read    = r;
      err_clr = c;
      was_full  = (q.size() == DP);
      was_empty = (q.size() == 0);
      @(posedge clk);
      if (r && !was_empty) void'(q.pop_front());
      if (w && !was_full) q.push_back(d);
      if (q.size() > 0) m_dout = q[0];
`ifdef FWFT_FIFO_ERR_EN
      m_ovf = (w && was_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = (r && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
`endif
      #1;
      write   = 1'b0;
      read    = 1'b0;
      err_clr = 1'b0;
      check_all(ph);
   endtask

   initial begin
      bit [DW-1:0] v;
      rst_n   = 1'b0;
      write   = 1'b0;
      read    = 1'b0;
      err_clr = 1'b0;
      din     = '0;
      m_dout  = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // Fill a non-power-of-two FIFO with 0x10..0x15.
      for (int i = 0; i < DP; i++) begin
         step("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
         if (i == AF - 1) begin
            chk("afull_at5", 32'(almost_full), 32'd1);
            chk("notfull_at5", 32'(full), 32'd0);
         end
      end
      chk("full_at6", 32'(full), 32'd1);

      // Write while full is dropped.
      step("drop", 1'b1, 8'hEE, 1'b0, 1'b0);
      chk("drop_count", 32'(count), 32'd6);

      // Drain in order; 0xEE must never surface.
      for (int i = 0; i < DP; i++) begin
         chk("drain_order", 32'(dout), 32'(8'h10 + i));
         step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("empty_after_drain", 32'(empty), 32'd1);

      // Fall-through with no read.
      step("fwft", 1'b1, 8'hA5, 1'b0, 1'b0);
      chk("fwft_dout", 32'(dout), 32'hA5);

      // Read plus write at count 1: new word becomes head.
      step("rw_at1", 1'b1, 8'h3C, 1'b1, 1'b0);
      step("pop_last", 1'b0, 8'h00, 1'b1, 1'b0);

      // Underflow, clear, and clear coincident with a new underflow.
      step("unf_set", 1'b0, 8'h00, 1'b1, 1'b0);
      step("unf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
      step("unf_set2", 1'b0, 8'h00, 1'b1, 1'b0);
      step("unf_setwins", 1'b0, 8'h00, 1'b1, 1'b1);
      step("unf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

      // Wrap-around streaming at count 3.
      for (int i = 0; i < 3; i++) step("pre3", 1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         v = 8'($urandom);
         step("stream3", 1'b1, v, 1'b1, 1'b0);
         chk("stream_count", 32'(count), 32'd3);
      end

      // Randomized traffic with shifting write/read bias to visit full and empty.
      for (int seg = 0; seg < 6; seg++) begin
         for (int i = 0; i < 50; i++) begin
            bit w, r, c;
            w = ($urandom_range(0, 9) < ((seg % 2 == 0) ? 8 : 3));
            r = ($urandom_range(0, 9) < ((seg % 2 == 0) ? 3 : 8));
            c = ($urandom_range(0, 15) == 0);
            step("rand", w, 8'($urandom), r, c);
         end
      end

      // Async reset mid-stream at count 4.
      while (q.size() > 4) step("to4", 1'b0, 8'h00, 1'b1, 1'b0);
      while (q.size() < 4) step("to4", 1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("pre_areset_count", 32'(count), 32'd4);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      check_all("areset");
      #2;
      rst_n = 1'b1;

      // Traffic after reset release.
      for (int i = 0; i < 40; i++) begin
         step("post", 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
